// File: rtl/y_enhance_pkg.sv
// y_enhance_pkg -- shared widths, constants and helpers for the luma
// sharpening block (y_enhance_top and y_line_matrix_3x3).
//   PIX_W   : luma width
//   GRAD_W  : signed Sobel component / unsigned magnitude width
//   SUM_W   : width of centre + scaled gradient before saturation
//   LATENCY : accept-to-output delay in clk cycles
//   SAT_MAX : saturation ceiling of the output luma
package y_enhance_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int SUM_W   = 12;
    localparam int LATENCY = 4;
    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic grad_t zext(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    // |v|; Sobel components never reach -1024, so no overflow.
    function automatic logic [GRAD_W-1:0] abs_grad(input grad_t v);
        return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/y_line_matrix_3x3.sv
// y_line_matrix_3x3 -- two line buffers plus a 3x3 pixel window.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   vsync, href, clken  : input frame/line valid and pixel strobe
//   y                   : input luma
//   p11..p33            : window (row 1 = oldest line, col 1 = oldest pixel)
//   win_ok              : window covers rows r-2..r and cols c-2..c fully
//   win_vld             : accept strobe delayed by one clk (window stage)
module y_line_matrix_3x3
    import y_enhance_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    input  logic clken,
    input  pix_t y,
    output pix_t p11, output pix_t p12, output pix_t p13,
    output pix_t p21, output pix_t p22, output pix_t p23,
    output pix_t p31, output pix_t p32, output pix_t p33,
    output logic win_ok,
    output logic win_vld
);

    localparam int COL_W = $clog2(IMG_HDISP);
    localparam int ROW_W = $clog2(IMG_VDISP + 1);

    pix_t lb0 [IMG_HDISP];  // previous line (r-1)
    pix_t lb1 [IMG_HDISP];  // line before that (r-2)

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             vsync_q, href_q, frame_en;
    logic             vs_rise, href_fall, accept;

    assign vs_rise   = vsync & ~vsync_q;
    assign href_fall = ~href & href_q;
    // Nothing is accepted after a reset until a fresh frame starts.
    assign accept    = clken & href & frame_en;

    // Line-buffer RAM: never reset. The read of lb0 sees the old value,
    // which cascades row r-1 into the r-2 buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= y;
            lb1[col] <= lb0[col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // vsync_q resets high so a reset inside an active frame is
            // not mistaken for a new frame start.
            vsync_q  <= 1'b1;
            href_q   <= 1'b0;
            frame_en <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            if (vs_rise) begin
                frame_en <= 1'b1;
                row      <= '0;
            end else if (href_fall && row != '1) begin
                row <= row + 1'b1;
            end
            if (href_fall)
                col <= '0;
            else if (accept && col != COL_W'(IMG_HDISP - 1))
                col <= col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            win_ok  <= 1'b0;
            win_vld <= 1'b0;
        end else begin
            win_vld <= accept;
            if (accept) begin
                p11 <= p12;  p12 <= p13;  p13 <= lb1[col];
                p21 <= p22;  p22 <= p23;  p23 <= lb0[col];
                p31 <= p32;  p32 <= p33;  p33 <= y;
                win_ok <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
            end
        end
    end

endmodule

// File: rtl/y_enhance_top.sv
// y_enhance_top -- Sobel edge enhancement of a streaming luma channel.
// post_img_Y = sat255(P + (|Gx|+|Gy|) >> GAIN_SHIFT), P = window centre.
// Pipeline: window -> Gx/Gy -> |Gx|+|Gy| -> add/saturate (4 clk).
// Optional: define Y_ENHANCE_CORING_EN to zero gradients below CORE_THRESH.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   per_frame_vsync/href/clken : input sync and pixel strobe
//   per_img_Y                  : input luma
//   post_frame_vsync/href      : input syncs delayed 4 clk
//   post_frame_clken           : accepted-pixel strobe delayed 4 clk
//   post_img_Y                 : enhanced luma, held while clken is low
module y_enhance_top
    import y_enhance_pkg::*;
#(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int GAIN_SHIFT  = 2,
    parameter int CORE_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_img_Y,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [PIX_W-1:0] post_img_Y
);

`ifdef Y_ENHANCE_CORING_EN
    localparam bit CORING = 1'b1;
`else
    localparam bit CORING = 1'b0;
`endif

    pix_t p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic win_ok, win_vld;

    y_line_matrix_3x3 #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_matrix (
        .clk     (clk),
        .rst     (rst),
        .vsync   (per_frame_vsync),
        .href    (per_frame_href),
        .clken   (per_frame_clken),
        .y       (per_img_Y),
        .p11 (p11), .p12 (p12), .p13 (p13),
        .p21 (p21), .p22 (p22), .p23 (p23),
        .p31 (p31), .p32 (p32), .p33 (p33),
        .win_ok  (win_ok),
        .win_vld (win_vld)
    );

    logic [LATENCY-1:0] vs_pipe, hs_pipe;
    logic [LATENCY:2]   vld_pipe;   // stage index matches pipeline stage

    grad_t              gx_n, gy_n, gx, gy;
    pix_t               p_s2, p_s3;
    logic [GRAD_W-1:0]  g_sum, g_core, g_s3;
    logic [SUM_W-1:0]   s_sum;

    always_comb begin
        gx_n   = (zext(p13) + (zext(p23) <<< 1) + zext(p33))
               - (zext(p11) + (zext(p21) <<< 1) + zext(p31));
        gy_n   = (zext(p31) + (zext(p32) <<< 1) + zext(p33))
               - (zext(p11) + (zext(p12) <<< 1) + zext(p13));
        g_sum  = abs_grad(gx) + abs_grad(gy);
        g_core = (CORING && (g_sum < GRAD_W'(CORE_THRESH))) ? '0 : g_sum;
        s_sum  = SUM_W'(p_s3) + SUM_W'(g_s3 >> GAIN_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_pipe    <= '0;
            hs_pipe    <= '0;
            vld_pipe   <= '0;
            gx         <= '0;
            gy         <= '0;
            p_s2       <= '0;
            p_s3       <= '0;
            g_s3       <= '0;
            post_img_Y <= '0;
        end else begin
            vs_pipe  <= {vs_pipe[LATENCY-2:0], per_frame_vsync};
            hs_pipe  <= {hs_pipe[LATENCY-2:0], per_frame_href};
            vld_pipe <= {vld_pipe[LATENCY-1:2], win_vld};
            // An incomplete window yields P=0, G=0, hence output 0.
            if (win_ok) begin
                gx   <= gx_n;
                gy   <= gy_n;
                p_s2 <= p22;
            end else begin
                gx   <= '0;
                gy   <= '0;
                p_s2 <= '0;
            end
            g_s3 <= g_core;
            p_s3 <= p_s2;
            if (vld_pipe[LATENCY-1])
                post_img_Y <= (s_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : s_sum[PIX_W-1:0];
        end
    end

    assign post_frame_vsync = vs_pipe[LATENCY-1];
    assign post_frame_href  = hs_pipe[LATENCY-1];
    assign post_frame_clken = vld_pipe[LATENCY];

endmodule

// File: tb/tb_y_enhance_top.sv
`timescale 1ns/1ps
module tb_y_enhance_top;

    localparam int W  = 640;
    localparam int H  = 5;
    localparam int GS = 2;
    localparam int CT = 16;
`ifdef Y_ENHANCE_CORING_EN
    localparam int C3A = 0, C3B = 3;
    localparam bit CORE = 1'b1;
`else
    localparam int C3A = 3, C3B = 6;
    localparam bit CORE = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] y = '0;
    logic       post_vs, post_hs, post_ck;
    logic [7:0] post_y;

    y_enhance_top #(
        .IMG_HDISP(W), .IMG_VDISP(H), .GAIN_SHIFT(GS), .CORE_THRESH(CT)
    ) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_Y(y),
        .post_frame_vsync(post_vs), .post_frame_href(post_hs),
        .post_frame_clken(post_ck), .post_img_Y(post_y)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int r; int c; int v; int t; } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        int kind; int lo; int hi; bit tog; int ref_i;
        int p0r; int p0c; int p0v; int p1r; int p1c; int p1v;
    } vec_t;
    vec_t tbl [7];
    int   sums [7];
    int   cnts [7];

    int  cap [H][W];
    int  csum, ocount;
    int  last_y = 0;
    bit  mon_en = 1'b0;

    // ---------------- reference model ----------------
    function automatic int pix(int kind, int lo, int hi, int r, int c);
        if (kind == 0) return (c < 320) ? lo : hi;
        return ((c * 73) ^ (r * 151) ^ (r * c * 7)) & 255;
    endfunction

    function automatic int expv(int kind, int lo, int hi, int r, int c);
        int p [3][3];
        int gx, gy, g, s;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = pix(kind, lo, hi, r - 2 + i, c - 2 + j);
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        g  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (CORE && g < CT) g = 0;
        s  = p[1][1] + (g >> GS);
        return (s > 255) ? 255 : s;
    endfunction

    // ---------------- sync history + output monitor ----------------
    logic [3:0] vs_h = '0, hs_h = '0;
    always @(posedge clk) begin
        if (rst) begin
            vs_h <= '0;
            hs_h <= '0;
        end else begin
            vs_h <= {vs_h[2:0], vsync};
            hs_h <= {hs_h[2:0], href};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (post_vs !== vs_h[3]) begin
                errors++;
                $display("FAIL vsync_delay t=%0d got=%b exp=%b", cyc, post_vs, vs_h[3]);
            end
            checks++;
            if (post_hs !== hs_h[3]) begin
                errors++;
                $display("FAIL href_delay t=%0d got=%b exp=%b", cyc, post_hs, hs_h[3]);
            end
            if (post_ck === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out t=%0d got=%0d exp=no output", cyc, post_y);
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (int'(post_y) != mon_e.v) begin
                        errors++;
                        $display("FAIL pix r=%0d c=%0d got=%0d exp=%0d", mon_e.r, mon_e.c, post_y, mon_e.v);
                    end
                    checks++;
                    if (cyc - mon_e.t != 4) begin
                        errors++;
                        $display("FAIL latency r=%0d c=%0d got=%0d exp=4", mon_e.r, mon_e.c, cyc - mon_e.t);
                    end
                    cap[mon_e.r][mon_e.c] = int'(post_y);
                    csum   = csum * 31 + int'(post_y);
                    ocount++;
                    last_y = int'(post_y);
                end
            end else begin
                checks++;
                if (int'(post_y) != last_y) begin
                    errors++;
                    $display("FAIL hold t=%0d got=%0d exp=%0d", cyc, post_y, last_y);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_zero_outputs(input string tag);
        checks++;
        if (post_vs !== 1'b0 || post_hs !== 1'b0 || post_ck !== 1'b0 || post_y !== 8'd0) begin
            errors++;
            $display("FAIL %s got=%b%b%b/%0d exp=000/0", tag, post_vs, post_hs, post_ck, post_y);
        end
    endtask

    // Runs one frame; abort_r >= 0 pulses rst at that pixel and ends the frame.
    task automatic run_frame(input int kind, input int lo, input int hi,
                             input bit tog, input int abort_r, input int abort_c);
        sb_t e;
        csum = 0;
        ocount = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                cap[r][c] = -1;
        @(negedge clk); vsync = 1'b1; href = 1'b0; clken = 1'b0;
        repeat (4) @(negedge clk);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == abort_r && c == abort_c) begin
                    @(negedge clk); #1;
                    rst = 1'b1;
                    sb.delete();
                    @(negedge clk);
                    check_zero_outputs("reset_midframe");
                    last_y = 0;
                    rst = 1'b0; href = 1'b0; vsync = 1'b0; clken = 1'b0;
                    repeat (8) @(negedge clk);
                    return;
                end
                if (tog) begin
                    @(negedge clk); href = 1'b1; clken = 1'b0; y = 8'($urandom);
                end
                @(negedge clk);
                href = 1'b1; clken = 1'b1; y = 8'(pix(kind, lo, hi, r, c));
                e.r = r; e.c = c; e.v = expv(kind, lo, hi, r, c); e.t = cyc;
                sb.push_back(e);
            end
            repeat (6) begin
                @(negedge clk); href = 1'b0; clken = tog ? 1'($urandom) : 1'b1; y = 8'($urandom);
            end
        end
        @(negedge clk); vsync = 1'b0; href = 1'b0; clken = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
            sb.delete();
        end
        checks++;
        if (ocount != W * H) begin
            errors++;
            $display("FAIL out_count got=%0d exp=%0d", ocount, W * H);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        //          kind lo  hi  tog ref  p0(r,c,v)      p1(r,c,v)
        tbl[0] = '{0, 100, 100, 1'b0, -1, 3, 101, 100,  1, 50,  0};
        tbl[1] = '{0,   0,  40, 1'b0, -1, 3, 320, 40,   3, 321, 80};
        tbl[2] = '{0,   0,  40, 1'b1,  1, 2,   1, 0,    4, 200, 0};
        tbl[3] = '{0,   0, 200, 1'b0, -1, 3, 321, 255,  3, 320, 200};
        tbl[4] = '{0,   0,   3, 1'b0, -1, 3, 320, C3A,  3, 321, C3B};
        tbl[5] = '{1,   0,   0, 1'b0, -1, 2,   0, 0,    4, 1,   0};
        tbl[6] = '{1,   0,   0, 1'b1,  5, 1, 639, 0,    0, 0,   0};

        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].kind, tbl[i].lo, tbl[i].hi, tbl[i].tog, -1, 0);
            sums[i] = csum;
            cnts[i] = ocount;
            checks++;
            if (cap[tbl[i].p0r][tbl[i].p0c] != tbl[i].p0v) begin
                errors++;
                $display("FAIL probe%0d_a got=%0d exp=%0d", i, cap[tbl[i].p0r][tbl[i].p0c], tbl[i].p0v);
            end
            checks++;
            if (cap[tbl[i].p1r][tbl[i].p1c] != tbl[i].p1v) begin
                errors++;
                $display("FAIL probe%0d_b got=%0d exp=%0d", i, cap[tbl[i].p1r][tbl[i].p1c], tbl[i].p1v);
            end
            if (tbl[i].ref_i >= 0) begin
                checks++;
                if (sums[i] != sums[tbl[i].ref_i] || cnts[i] != cnts[tbl[i].ref_i]) begin
                    errors++;
                    $display("FAIL gap_vs_cont%0d got=%0d exp=%0d", i, sums[i], sums[tbl[i].ref_i]);
                end
            end
        end

        // Mid-frame reset, then a clean frame must match the golden run.
        run_frame(0, 0, 40, 1'b0, 3, 100);
        run_frame(0, 0, 40, 1'b0, -1, 0);
        checks++;
        if (csum != sums[1] || ocount != cnts[1]) begin
            errors++;
            $display("FAIL post_reset_frame got=%0d exp=%0d", csum, sums[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
